// File: rtl/poci_pkg.sv
// Shared types and the address wrap rule for the POCI burst readout engine.
package poci_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} poci_state_t;

  localparam int unsigned RESERVED_ADDR = 0;

  // Valid range is 1..num_regs; the top and any invalid address both wrap to 1.
  function automatic int unsigned next_addr(input int unsigned addr, input int unsigned num_regs);
    if (addr == RESERVED_ADDR || addr >= num_regs) next_addr = 1;
    else next_addr = addr + 1;
  endfunction

endpackage

// File: rtl/poci_word_sel.sv
// Combinational register-word select with range check; zero word on reserved/out-of-range address.
module poci_word_sel
  import poci_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 59,
  parameter int ADDR_W   = 8
) (
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic [ADDR_W-1:0]          addr,
  output logic [DATA_W-1:0]          word,
  output logic                       err
);

  always_comb begin
    err  = (addr == ADDR_W'(RESERVED_ADDR)) || (32'(addr) > NUM_REGS);
    word = '0;
    for (int a = 1; a <= NUM_REGS; a++) begin
      if (32'(addr) == a) word = regs_flat[(a-1)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/poci_burst_readout.sv
// SPI readout engine: one LOAD cycle, then L*DATA_W contiguous serial bits with no inter-word gap.
// No backpressure: rd_start is only accepted in IDLE; starts while busy are dropped.
module poci_burst_readout
  import poci_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 59,
  parameter int ADDR_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int MSB_FIRST = 0,
  localparam int BURST_W  = $clog2(MAX_BURST+1)
) (
  input  logic                       sclk,
  input  logic                       rst,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic                       rd_start,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic [BURST_W-1:0]         rd_len,
  input  logic                       auto_inc,
  output logic                       serial_out,
  output logic                       sout_valid,
  output logic                       busy,
  output logic                       word_done,
  output logic                       burst_done,
  output logic                       addr_err
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W-1);

  poci_state_t         state;
  logic [DATA_W-1:0]   shreg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [BURST_W-1:0]  words_left;
  logic [ADDR_W-1:0]   addr_q;
  logic                inc_q;

  logic [DATA_W-1:0]   sel_word;
  logic                sel_err;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [BURST_W-1:0]  len_eff;
  logic [DATA_W-1:0]   shifted;

  // addr_q always names the next word to be loaded, so the selector never needs a lookahead.
  poci_word_sel #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_word_sel (
    .regs_flat (regs_flat),
    .addr      (addr_q),
    .word      (sel_word),
    .err       (sel_err)
  );

  assign addr_nxt = inc_q ? ADDR_W'(next_addr(32'(addr_q), NUM_REGS)) : addr_q;

  always_comb begin
    len_eff = rd_len;
    if (rd_len == '0) len_eff = BURST_W'(1);
    else if (32'(rd_len) > MAX_BURST) len_eff = BURST_W'(MAX_BURST);
  end

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign shifted = {shreg[DATA_W-2:0], 1'b0};
    end else begin : g_lsb
      assign shifted = {1'b0, shreg[DATA_W-1:1]};
    end
  endgenerate

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
      addr_q     <= '0;
      inc_q      <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_start) begin
            addr_q     <= rd_addr;
            inc_q      <= auto_inc;
            words_left <= len_eff;
            addr_err   <= 1'b0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          shreg   <= sel_word;
          bit_cnt <= '0;
          addr_q  <= addr_nxt;
          if (sel_err) addr_err <= 1'b1;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            if (words_left > BURST_W'(1)) begin
              shreg      <= sel_word;
              bit_cnt    <= '0;
              addr_q     <= addr_nxt;
              words_left <= words_left - BURST_W'(1);
              if (sel_err) addr_err <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            shreg   <= shifted;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // LOAD counts as busy but drives no data bit, keeping valid bits exactly L*DATA_W.
  assign busy       = (state == LOAD) || (state == SHIFT);
  assign sout_valid = (state == SHIFT);
  assign serial_out = sout_valid & ((MSB_FIRST != 0) ? shreg[DATA_W-1] : shreg[0]);
  assign word_done  = (state == SHIFT) && (bit_cnt == LAST_BIT);
  assign burst_done = word_done && (words_left == BURST_W'(1));

endmodule
